// File: rtl/game_life_ctrl.sv
// Game-state controller for the sprite/collision mixer: turns character-death
// events into per-character valid flags, score, robot lives and respawn timing.
module game_life_ctrl #(
    parameter int DRAGON_RESPAWN = 60,
    parameter int ROBOT_RESPAWN  = 90,
    parameter int LIVES_INIT     = 3,
    parameter int SCORE_MAX      = 999,
    parameter int TIMER_W        = 8
) (
    input  logic       clk_25Hz,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [3:0] Event,
    output logic       d_valid,
    output logic       d1_valid,
    output logic       d2_valid,
    output logic       r_valid,
    output logic [9:0] score,
    output logic [1:0] lives,
    output logic       kill_pulse,
    output logic       game_over
);
    typedef enum logic [1:0] {IDLE, PLAY, ROBOT_DOWN, GAME_OVER} state_t;

    localparam logic [TIMER_W-1:0] D_RELOAD = TIMER_W'(DRAGON_RESPAWN);
    localparam logic [TIMER_W-1:0] R_RELOAD = TIMER_W'(ROBOT_RESPAWN);
    localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);
    localparam logic [1:0]         L_INIT   = 2'(LIVES_INIT);
    localparam logic [9:0]         S_MAX    = 10'(SCORE_MAX);

    state_t             state, state_n;
    logic [3:0]         ev_q, new_q;
    // dval[2] is dragon0 ... dval[0] is dragon2, lining up with Event[3:1]
    logic [2:0]         dval, dval_n;
    logic               rval, rval_n;
    logic [TIMER_W-1:0] dtmr   [3];
    logic [TIMER_W-1:0] dtmr_n [3];
    logic [TIMER_W-1:0] rtmr, rtmr_n;
    logic [9:0]         score_n;
    logic [1:0]         lives_n;
    logic               kill_n;
    logic [2:0]         dkill;
    logic [1:0]         kill_cnt;

    function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [1:0] b);
        logic [10:0] sum;
        sum = {1'b0, a} + {9'b0, b};
        if (sum > {1'b0, S_MAX}) return S_MAX;
        return sum[9:0];
    endfunction

    always_comb begin
        state_n  = state;
        dval_n   = dval;
        rval_n   = rval;
        dtmr_n   = dtmr;
        rtmr_n   = rtmr;
        score_n  = score;
        lives_n  = lives;
        kill_n   = 1'b0;
        dkill    = '0;
        kill_cnt = '0;
        case (state)
            IDLE, GAME_OVER: begin
                if (start) begin
                    state_n = PLAY;
                    dval_n  = '1;
                    rval_n  = 1'b1;
                    score_n = '0;
                    lives_n = L_INIT;
                    for (int k = 0; k < 3; k++) dtmr_n[k] = '0;
                    rtmr_n  = '0;
                end
            end
            PLAY, ROBOT_DOWN: begin
                dkill = new_q[3:1] & dval;
                // A death in the same cycle as a tick reloads instead of decrementing
                for (int k = 0; k < 3; k++) begin
                    if (dkill[k]) begin
                        dval_n[k] = 1'b0;
                        dtmr_n[k] = D_RELOAD;
                    end else if (tick && dtmr[k] != '0) begin
                        dtmr_n[k] = dtmr[k] - T_ONE;
                        if (dtmr[k] == T_ONE) dval_n[k] = 1'b1;
                    end
                end
                kill_cnt = 2'(dkill[0]) + 2'(dkill[1]) + 2'(dkill[2]);
                if (kill_cnt != 2'd0) begin
                    score_n = sat_add(score, kill_cnt);
                    kill_n  = 1'b1;
                end
                if (state == PLAY) begin
                    if (new_q[0] && rval) begin
                        rval_n = 1'b0;
                        if (lives <= 2'd1) begin
                            state_n = GAME_OVER;
                            lives_n = 2'd0;
                            dval_n  = '0;
                        end else begin
                            state_n = ROBOT_DOWN;
                            lives_n = lives - 2'd1;
                            rtmr_n  = R_RELOAD;
                        end
                    end
                end else if (tick && rtmr != '0) begin
                    rtmr_n = rtmr - T_ONE;
                    if (rtmr == T_ONE) begin
                        rval_n  = 1'b1;
                        state_n = PLAY;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_25Hz or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk_25Hz or negedge rst) begin
        if (!rst) begin
            ev_q       <= '0;
            new_q      <= '0;
            dval       <= '0;
            rval       <= 1'b0;
            for (int k = 0; k < 3; k++) dtmr[k] <= '0;
            rtmr       <= '0;
            score      <= '0;
            lives      <= L_INIT;
            kill_pulse <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            // rising-edge detect stage: only newly asserted death bits act
            ev_q       <= Event;
            new_q      <= Event & ~ev_q;
            // game state stage
            dval       <= dval_n;
            rval       <= rval_n;
            dtmr       <= dtmr_n;
            rtmr       <= rtmr_n;
            score      <= score_n;
            lives      <= lives_n;
            kill_pulse <= kill_n;
            game_over  <= (state_n == GAME_OVER);
        end
    end

    assign d_valid  = dval[2];
    assign d1_valid = dval[1];
    assign d2_valid = dval[0];
    assign r_valid  = rval;
endmodule
